// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- instruction-fetch stage sitting directly after the PC register.
//
// Computes nextPC for the PC register, which loads it on every clock edge, so
// holding the PC means driving nextPC = PC. Keeps at most one instruction
// memory read outstanding and hands {instr, pc, pc+PC_STEP} to decode over a
// valid/ready handshake. A redirect from execute squashes any wrong-path
// fetch that is still in flight.
//
// Build option:
//   IF_MISALIGN_TRAP_EN  when defined, a PC with PC[1:0] != 0 issues no read.
//                        Instead a trap bundle (id_misaligned=1,
//                        id_instr=RESET_INSTR) is delivered. When undefined,
//                        the low PC bits are dropped from the address and
//                        id_misaligned is always 0.
//
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   PC / nextPC                    current PC in, next PC out (combinational)
//   branch_taken, branch_target    one-cycle redirect request from execute
//   imem_req/addr/ready            read request channel
//   imem_rvalid/rdata              read response channel
//   id_valid/ready                 handshake to decode
//   id_instr/pc/pc4/misaligned     fetch bundle
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] PC,
    output logic [31:0] nextPC,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_misaligned
);

    // state  | meaning
    // S_REQ  | presenting a read request (or a misaligned trap)
    // S_WAIT | one read outstanding, waiting for imem_rvalid
    // S_HOLD | bundle presented to decode, waiting for id_ready
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        kill;
    logic [31:0] fetch_pc;
    logic        misalign;
    logic        accept;
    logic        trap;
    logic        rsp_take;

`ifdef IF_MISALIGN_TRAP_EN
    assign misalign = (PC[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign imem_addr = {PC[31:2], 2'b00};
    assign accept    = imem_req && imem_ready;
    assign trap      = (state == S_REQ) && !branch_taken && misalign;
    // A response arriving together with a redirect is wrong-path as well.
    assign rsp_take  = (state == S_WAIT) && imem_rvalid && !kill && !branch_taken;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_REQ: begin
                if (trap) begin
                    state_nxt = S_HOLD;
                end else if (accept) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = rsp_take ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (id_ready || branch_taken) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req = (state == S_REQ) && !branch_taken && !misalign;
        nextPC   = PC;
        if (branch_taken) begin
            nextPC = branch_target;
        end else if (imem_req && imem_ready) begin
            nextPC = PC + PC_STEP;
        end
    end

    // Squash flag, fetch address and the fetch bundle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kill          <= 1'b0;
            fetch_pc      <= 32'h0;
            id_valid      <= 1'b0;
            id_instr      <= RESET_INSTR;
            id_pc         <= 32'h0;
            id_pc4        <= 32'h0;
            id_misaligned <= 1'b0;
        end else begin
            if (state == S_WAIT) begin
                if (imem_rvalid) begin
                    kill <= 1'b0;
                end else if (branch_taken) begin
                    kill <= 1'b1;
                end
            end

            if (accept) begin
                fetch_pc <= PC;
            end

            if (rsp_take) begin
                id_valid      <= 1'b1;
                id_instr      <= imem_rdata;
                id_pc         <= fetch_pc;
                id_pc4        <= fetch_pc + PC_STEP;
                id_misaligned <= 1'b0;
            end else if (trap) begin
                id_valid      <= 1'b1;
                id_instr      <= RESET_INSTR;
                id_pc         <= PC;
                id_pc4        <= PC + PC_STEP;
                id_misaligned <= 1'b1;
            end else if ((state == S_HOLD) && (id_ready || branch_taken)) begin
                id_valid      <= 1'b0;
                id_misaligned <= 1'b0;
            end
        end
    end

endmodule
